// File: rtl/mem_wait_responder_pkg.sv
// Shared widths and FSM encodings for the wait-state memory responder.
package mem_wait_responder_pkg;

    localparam int MWR_ADDRESS_WIDTH = 26;
    localparam int MWR_DATA_WIDTH    = 32;
    localparam int CNT_W             = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/mem_wait_responder_mem_array.sv
// Single-port backing store: synchronous write, registered read, no reset.
module mem_array
    import mem_wait_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_WIDTH = MWR_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_wait_responder.sv
// Memory-port responder: accepts a read/write, waits WAIT_CYCLES, then pulses READY
// with read data and an error flag for illegal or out-of-range requests.
module mem_wait_responder
    import mem_wait_responder_pkg::*;
#(
    parameter int ADDRESS_WIDTH = MWR_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = MWR_DATA_WIDTH,
    parameter int DEPTH_LOG2    = 8,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDRESS_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0]    DATA_IN,
    input  logic                     READ,
    input  logic                     WRITE,
    output logic [DATA_WIDTH-1:0]    DATA_OUT,
    output logic                     READY,
    output logic                     ERR,
    output logic                     BUSY
);

    state_t                   state, state_next;
    logic [CNT_W-1:0]         cnt;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic                     rd_q, wr_q;

    logic                     accept, enter_resp;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_data;
    logic                     req_rd, req_wr, req_bad;
    logic                     mem_we, mem_re;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     rd_valid;

    assign accept = (state == IDLE) && (READ || WRITE);

    // With zero wait states RESP is entered on the accept edge itself, so the
    // live inputs are used there; otherwise the latched request is used.
    assign req_addr = (state == IDLE) ? ADDR    : addr_q;
    assign req_data = (state == IDLE) ? DATA_IN : data_q;
    assign req_rd   = (state == IDLE) ? READ    : rd_q;
    assign req_wr   = (state == IDLE) ? WRITE   : wr_q;
    assign req_bad  = (req_rd && req_wr) || (|req_addr[ADDRESS_WIDTH-1:DEPTH_LOG2]);

    assign enter_resp = (state_next == RESP) && (state != RESP);
    assign mem_we     = enter_resp && !RST && req_wr && !req_bad;
    assign mem_re     = enter_resp && !RST && req_rd && !req_bad;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (READ || WRITE) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        READY = (state == RESP);
        BUSY  = (state != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(WAIT_CYCLES);
        end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            addr_q <= ADDR;
            data_q <= DATA_IN;
            rd_q   <= READ;
            wr_q   <= WRITE;
        end
    end

    // ERR lives only for the RESP cycle; rd_valid masks the array's output so a
    // failed read reads back as zero and writes leave DATA_OUT untouched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR      <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            ERR <= enter_resp && req_bad;
            if (enter_resp && req_rd) begin
                rd_valid <= !req_bad;
            end
        end
    end

    assign DATA_OUT = rd_valid ? mem_rdata : '0;

    mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (CLK),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (req_addr[DEPTH_LOG2-1:0]),
        .wdata (req_data),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mem_wait_responder.sv
// Scoreboard bench for mem_wait_responder: a 2-wait-state instance and a 0-wait-state instance.
module tb_mem_wait_responder;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [25:0] addr = '0, addr0 = '0;
    logic [31:0] din = '0, din0 = '0;
    logic        rd = 1'b0, wr = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] dout, dout0;
    logic        ready, err, busy, ready0, err0, busy0;

    exp_t        sb[$];
    logic [31:0] model[int];
    logic [31:0] model0[int];
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_wait_responder #(.ADDRESS_WIDTH(26), .DATA_WIDTH(32), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut (
        .CLK(clk), .RST(rst), .ADDR(addr), .DATA_IN(din), .READ(rd), .WRITE(wr),
        .DATA_OUT(dout), .READY(ready), .ERR(err), .BUSY(busy)
    );

    mem_wait_responder #(.ADDRESS_WIDTH(26), .DATA_WIDTH(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
        .CLK(clk), .RST(rst), .ADDR(addr0), .DATA_IN(din0), .READ(rd0), .WRITE(wr0),
        .DATA_OUT(dout0), .READY(ready0), .ERR(err0), .BUSY(busy0)
    );

    // One transaction on the 2-wait instance; expectation is pushed before driving.
    task automatic req(input logic [25:0] a, input logic [31:0] d, input logic r, input logic w,
                       input string nm);
        exp_t e;
        logic bad;
        int   lat;
        int   busy_n;
        bad = (r && w) || (a[25:8] != 18'd0);
        e.name = nm;
        e.err = bad;
        e.chk_data = r;
        e.data = (r && !bad) ? (model.exists(int'(a)) ? model[int'(a)] : 32'hx) : 32'h0;
        if (w && !bad) model[int'(a)] = d;
        sb.push_back(e);
        @(negedge clk);
        addr = a; din = d; rd = r; wr = w;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        addr = 26'($urandom); din = $urandom;
        lat = 1; busy_n = 0;
        while (!ready && lat < 20) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (busy) busy_n++;
        e = sb.pop_front();
        n_cmp++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, expected 3", e.name, lat);
        end
        n_cmp++;
        if (busy_n !== 3) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d, expected 3", e.name, busy_n);
        end
        n_cmp++;
        if (err !== e.err) begin
            n_fail++;
            $display("FAIL %s err: got %b, expected %b", e.name, err, e.err);
        end
        if (e.chk_data) begin
            n_cmp++;
            if (dout !== e.data) begin
                n_fail++;
                $display("FAIL %s data: got %h, expected %h", e.name, dout, e.data);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, ready, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s after_resp busy/ready/err: got %b, expected 000", e.name, {busy, ready, err});
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({dout, ready, err, busy} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_init: got dout=%h r=%b e=%b b=%b, expected all 0", dout, ready, err, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_rw;
        req(26'h005, 32'hDEADBEEF, 1'b0, 1'b1, "write_05");
        req(26'h005, 32'h0, 1'b1, 1'b0, "read_05");
        req(26'h000, 32'h0BADF00D, 1'b0, 1'b1, "write_00");
        req(26'h007, 32'hA5A5A5A5, 1'b0, 1'b1, "write_07");
        req(26'h010, 32'h11111111, 1'b0, 1'b1, "write_10");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        addr = 26'h005; rd = 1'b1; wr = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({dout, ready, err, busy} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_async: got dout=%h r=%b e=%b b=%b, expected all 0", dout, ready, err, busy);
        end
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({dout, ready, err, busy} !== 35'h0) begin
                n_fail++;
                $display("FAIL reset_hold: got dout=%h r=%b e=%b b=%b, expected all 0", dout, ready, err, busy);
            end
        end
        rd = 1'b0; wr = 1'b0;
        rst = 1'b0;
        // Reset landing in the RESP cycle must kill READY at once.
        @(negedge clk);
        addr = 26'h005; rd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || dout !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL pre_reset_resp: got r=%b dout=%h, expected 1 deadbeef", ready, dout);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({dout, ready, busy} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_in_resp: got dout=%h r=%b b=%b, expected all 0", dout, ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_errors;
        req(26'h100, 32'h00001234, 1'b0, 1'b1, "write_oor");
        req(26'h100, 32'h0, 1'b1, 1'b0, "read_oor");
        req(26'h000, 32'h0, 1'b1, 1'b0, "read_00");
        req(26'h007, 32'h0, 1'b1, 1'b1, "illegal_07");
        req(26'h007, 32'h0, 1'b1, 1'b0, "read_07");
        req(26'h2000010, 32'h0, 1'b1, 1'b0, "read_high_alias");
    endtask

    task automatic test_reset_drops_write;
        int rdy_seen;
        @(negedge clk);
        addr = 26'h010; din = 32'h00000055; wr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rdy_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ready) rdy_seen++;
        end
        n_cmp++;
        if (rdy_seen !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dropped_write: got ready_pulses=%0d busy=%b, expected 0 0", rdy_seen, busy);
        end
        req(26'h010, 32'h0, 1'b1, 1'b0, "read_10_after_drop");
    endtask

    task automatic req0_write(input logic [25:0] a, input logic [31:0] d);
        @(negedge clk);
        addr0 = a; din0 = d; wr0 = 1'b1;
        model0[int'(a)] = d;
        @(posedge clk);
        @(negedge clk);
        wr0 = 1'b0;
        n_cmp++;
        if (ready0 !== 1'b1 || err0 !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_write_%0h: got r=%b e=%b, expected 1 0", a, ready0, err0);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   idx;
        req0_write(26'h000, 32'h0A0A0001);
        req0_write(26'h001, 32'h0B0B0002);
        req0_write(26'h002, 32'h0C0C0003);
        for (int i = 0; i < 3; i++) begin
            e.name = $sformatf("zw_read_%0d", i);
            e.err = 1'b0;
            e.chk_data = 1'b1;
            e.data = model0[i];
            sb.push_back(e);
        end
        idx = 0;
        @(negedge clk);
        addr0 = 26'h000; rd0 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ready0 !== ((c % 2) == 0)) begin
                n_fail++;
                $display("FAIL zw_ready_pattern c%0d: got %b, expected %b", c, ready0, (c % 2) == 0);
            end
            if (ready0 && sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (dout0 !== e.data || err0 !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got %h err=%b, expected %h err=%b", e.name, dout0, err0, e.data, e.err);
                end
                idx++;
                addr0 = 26'(idx);
                if (idx == 3) rd0 = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL zw_scoreboard_left: got %0d entries, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_reset_mid();
        test_errors();
        test_reset_drops_write();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_wait_responder.md
Name: mem_wait_responder

Overview:
- Memory-side responder for the processor's memory port. It accepts one read or write per request from the data path, inserts a configurable number of wait states, then returns READY and, for reads, the read data.
- It holds a 2^DEPTH_LOG2 x 32 word backing store and flags out-of-range or illegal requests on ERR.
- It sits between the CPU data path (ADDR, write data, READ/WRITE strobes) and the system bus/testbench.

Parameters:
ADDRESS_WIDTH, 26, word address width from the processor
DATA_WIDTH, 32, data word width
DEPTH_LOG2, 8, log2 of backing-store depth in words (256)
WAIT_CYCLES, 2, wait states between accept and response (0..15)

Ports:
CLK  input  1  clock, rising-edge active
RST  input  1  reset, asynchronous, active-high
ADDR  input  ADDRESS_WIDTH  word address of request
DATA_IN  input  DATA_WIDTH  write data from processor
READ  input  1  read request strobe
WRITE  input  1  write request strobe
DATA_OUT  output  DATA_WIDTH  registered read data
READY  output  1  one-cycle response pulse
ERR  output  1  error flag, valid only while READY=1
BUSY  output  1  high whenever state != IDLE

Behaviour:
- Interface decision: one clock CLK; reset RST is asynchronous and active-high.
- Reset values:
  - State goes to IDLE and the wait counter to 0.
  - DATA_OUT=0, READY=0, ERR=0, BUSY=0.
  - Backing-store contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - At an edge where READ|WRITE=1, latch ADDR, DATA_IN, op and the illegal flag (READ&WRITE). This is the accept edge t0.
  - If WAIT_CYCLES=0, go to RESP. Otherwise go to WAIT with cnt=WAIT_CYCLES.
- WAIT:
  - Each edge decrements cnt.
  - At the edge where cnt==1, go to RESP. Result: RESP is entered at edge t0+WAIT_CYCLES.
- Edge entering RESP, write:
  - Legal and in range: array[addr] <= data.
  - Otherwise: no array change.
- Edge entering RESP, read:
  - Legal and in range: DATA_OUT <= array[addr].
  - Otherwise: DATA_OUT <= 0.
- Edge entering RESP, ERR: ERR <= illegal | out_of_range, where out_of_range = latched ADDR bits [ADDRESS_WIDTH-1:DEPTH_LOG2] nonzero.
- READY: high for exactly the one cycle in RESP. The next edge returns to IDLE, clears READY and ERR, and holds DATA_OUT.
- Strobe timing:
  - Strobes are ignored in WAIT and RESP.
  - Strobes still high in IDLE after RESP start a new request, so a held strobe yields back-to-back transactions.
  - The requester deasserts the strobe in the cycle READY is seen.
- Latched request: ADDR and DATA_IN changes after t0 do not affect the transaction in flight.
- Reset mid-operation (WAIT or RESP): return to IDLE immediately, drop any pending write, no READY pulse.
- Addressing: array index = latched ADDR[DEPTH_LOG2-1:0]. No wrap-around; higher bits nonzero means an error.

Decomposition:
- Shared definitions file: ADDRESS_WIDTH, DATA_WIDTH, and the state encodings IDLE=2'b00, WAIT=2'b01, RESP=2'b10.
- One sub-module, mem_array: single-port, synchronous write, registered read, DEPTH_LOG2/DATA_WIDTH parameterised, no reset.
- FSM, counter and request latches live in mem_wait_responder.

Test Plan:
1. RST=1 mid-simulation with strobes active -> DATA_OUT=0, READY=0, ERR=0, BUSY=0 immediately (asynchronous), held while RST=1.
2. WAIT_CYCLES=2: WRITE ADDR=0x05, DATA_IN=0xDEADBEEF accepted at t0 -> READY in the cycle after edge t0+2, ERR=0. Then READ ADDR=0x05 -> READY after 2 cycles, DATA_OUT=0xDEADBEEF, BUSY=1 for 3 cycles.
3. WRITE ADDR=0x100, data 0x1234 -> READY with ERR=1. A following read of 0x100 -> DATA_OUT=0, ERR=1. A read of 0x000 returns its previous value.
4. READ=WRITE=1 at ADDR=0x07 holding 0xA5A5A5A5 -> READY with ERR=1, DATA_OUT=0. A following read of 0x07 returns 0xA5A5A5A5.
5. WRITE 0x10 = 0x55 accepted, then RST pulsed during WAIT -> no READY, BUSY=0. A later read of 0x10 returns its pre-write value.
6. WAIT_CYCLES=0 with READ held high and ADDR stepping 0,1,2 -> READY every second cycle with DATA_OUT = array[0], array[1], array[2] in order.
